// File: rtl/frame_packer.sv
// Packs eight 16-bit words into a 140-bit {chan, payload, crc8} FIFO word.
// The packed word is held on the write port until the FIFO is not full.
module frame_packer #(
  parameter int unsigned WORDS_PER_FRAME = 8,
  parameter logic [7:0]  CRC_POLY        = 8'h07
) (
  input  logic           clk_in,
  input  logic           rst_n,
  input  logic [15:0]    in_data,
  input  logic [3:0]     in_chan,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_abort,
  output logic [139:0]   data_to_fifo,
  output logic           fifo_w_enable,
  input  logic           fifo_full,
  output logic           err_chan,
  output logic [15:0]    frame_cnt
);

  localparam logic [2:0] LastIdx = 3'(WORDS_PER_FRAME - 1);

  typedef enum logic [0:0] {StCollect, StHold} state_e;

  state_e         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [3:0]     chan_q, chan_d;
  logic [7:0]     crc_q, crc_d;
  logic [127:0]   payload_q, payload_d;
  logic [139:0]   data_q, data_d;
  logic           w_en_q, w_en_d;
  logic           err_chan_q, err_chan_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic           restart;
  logic [2:0]     slot;

  // MSB-first CRC-8 over one 16-bit word, init supplied by caller.
  function automatic logic [7:0] crc_step(input logic [7:0] crc_in, input logic [15:0] word);
    logic [7:0] c;
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ word[i]) c = {c[6:0], 1'b0} ^ CRC_POLY;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    chan_d      = chan_q;
    crc_d       = crc_q;
    payload_d   = payload_q;
    data_d      = data_q;
    w_en_d      = w_en_q;
    err_chan_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    in_ready    = 1'b0;
    restart     = (idx_q == 3'd0) || (in_chan != chan_q);
    slot        = LastIdx - idx_q;

    unique case (state_q)
      StCollect: begin
        in_ready = !in_abort;
        if (in_abort) begin
          idx_d = 3'd0;
          crc_d = 8'h00;
        end else if (in_valid) begin
          if (restart) begin
            // A mismatching word starts a fresh frame as its word 0.
            err_chan_d = (idx_q != 3'd0);
            chan_d     = in_chan;
            crc_d      = crc_step(8'h00, in_data);
            payload_d  = {in_data, 112'h0};
            idx_d      = 3'd1;
          end else begin
            crc_d                         = crc_step(crc_q, in_data);
            payload_d[{slot, 4'b0} +: 16] = in_data;
            if (idx_q == LastIdx) begin
              data_d  = {chan_q, payload_d, crc_d};
              w_en_d  = 1'b1;
              idx_d   = 3'd0;
              state_d = StHold;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      end
      StHold: begin
        if (!fifo_full) begin
          w_en_d      = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          idx_d       = 3'd0;
          state_d     = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StCollect;
      idx_q       <= 3'd0;
      chan_q      <= 4'h0;
      crc_q       <= 8'h00;
      payload_q   <= 128'h0;
      data_q      <= 140'h0;
      w_en_q      <= 1'b0;
      err_chan_q  <= 1'b0;
      frame_cnt_q <= 16'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      chan_q      <= chan_d;
      crc_q       <= crc_d;
      payload_q   <= payload_d;
      data_q      <= data_d;
      w_en_q      <= w_en_d;
      err_chan_q  <= err_chan_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign data_to_fifo  = data_q;
  assign fifo_w_enable = w_en_q;
  assign err_chan      = err_chan_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer: framing, CRC, hold/backpressure, abort,
// channel mismatch, back-to-back throughput and reset in HOLD.
module tb_frame_packer;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic [15:0]  in_data;
  logic [3:0]   in_chan;
  logic         in_valid;
  logic         in_ready;
  logic         in_abort;
  logic [139:0] data_to_fifo;
  logic         fifo_w_enable;
  logic         fifo_full;
  logic         err_chan;
  logic [15:0]  frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int           writes = 0;
  int           en_cycles = 0;
  int           err_cnt = 0;
  logic [139:0] last_word = '0;
  logic [15:0]  fw [8];

  frame_packer dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_chan      (in_chan),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_abort     (in_abort),
    .data_to_fifo (data_to_fifo),
    .fifo_w_enable(fifo_w_enable),
    .fifo_full    (fifo_full),
    .err_chan     (err_chan),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk_in = ~clk_in;

  // Observe FIFO-side writes and error pulses at each edge.
  always @(posedge clk_in) begin
    if (rst_n) begin
      if (fifo_w_enable) en_cycles <= en_cycles + 1;
      if (fifo_w_enable && !fifo_full) begin
        writes    <= writes + 1;
        last_word <= data_to_fifo;
      end
      if (err_chan) err_cnt <= err_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [139:0] got, input logic [139:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8_model(input logic [7:0] c_in, input logic [15:0] w);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int i = 15; i >= 0; i--) begin
      fb = c[7] ^ w[i];
      c  = (c << 1) ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [139:0] make_frame(input logic [3:0] ch);
    logic [127:0] p;
    logic [7:0]   c;
    p = '0;
    c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      p = {p[111:0], fw[i]};
      c = crc8_model(c, fw[i]);
    end
    return {ch, p, c};
  endfunction

  task automatic send_word(input logic [15:0] d, input logic [3:0] c);
    in_data  = d;
    in_chan  = c;
    in_valid = 1'b1;
    @(posedge clk_in);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int           w0, e0, r0, bad, rdy_cnt, n;
    logic [139:0] held;
    logic         rdy, rdy9, rdy18;

    rst_n = 1'b0; in_data = '0; in_chan = '0; in_valid = 1'b0;
    in_abort = 1'b0; fifo_full = 1'b0;
    #12;
    check_eq("rst_in_ready", 140'(in_ready), 140'(1));
    check_eq("rst_w_en", 140'(fifo_w_enable), 140'(0));
    check_eq("rst_data", data_to_fifo, 140'h0);
    check_eq("rst_cnt", 140'(frame_cnt), 140'(0));
    check_eq("rst_err", 140'(err_chan), 140'(0));
    @(negedge clk_in); rst_n = 1'b1;
    tick();

    // Basic frame: 7 zeros then 1, CRC is 8'h07.
    for (int i = 0; i < 7; i++) send_word(16'h0000, 4'h3);
    send_word(16'h0001, 4'h3);
    check_eq("t1_w_en_hi", 140'(fifo_w_enable), 140'(1));
    check_eq("t1_data", data_to_fifo, {4'h3, 112'h0, 16'h0001, 8'h07});
    tick();
    check_eq("t1_w_en_lo", 140'(fifo_w_enable), 140'(0));
    check_eq("t1_cnt", 140'(frame_cnt), 140'(1));
    check_eq("t1_ready", 140'(in_ready), 140'(1));
    check_eq("t1_writes", 140'(writes), 140'(1));
    check_eq("t1_en_cycles", 140'(en_cycles), 140'(1));

    // Hold under backpressure for 5 cycles.
    w0 = writes; e0 = en_cycles; bad = 0;
    fifo_full = 1'b1;
    for (int i = 0; i < 8; i++) fw[i] = 16'h1111 * 16'(i + 1);
    for (int i = 0; i < 8; i++) send_word(fw[i], 4'h7);
    held = data_to_fifo;
    check_eq("t2_data", held, make_frame(4'h7));
    check_eq("t2_ready_hold", 140'(in_ready), 140'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      if (data_to_fifo !== held || in_ready !== 1'b0 || fifo_w_enable !== 1'b1) bad++;
    end
    check_eq("t2_stable", 140'(bad), 140'(0));
    fifo_full = 1'b0;
    tick();
    check_eq("t2_w_en_lo", 140'(fifo_w_enable), 140'(0));
    check_eq("t2_writes", 140'(writes - w0), 140'(1));
    check_eq("t2_en_cycles", 140'(en_cycles - e0), 140'(6));
    check_eq("t2_word", last_word, held);

    // Abort after 3 words; the aborting word is not accepted.
    w0 = writes;
    send_word(16'hA5A5, 4'h1);
    send_word(16'h5A5A, 4'h1);
    send_word(16'h1234, 4'h1);
    in_abort = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF; in_chan = 4'h1;
    #1;
    check_eq("t3_ready_abort", 140'(in_ready), 140'(0));
    @(posedge clk_in); #1;
    in_abort = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) fw[i] = 16'hFFFF;
    for (int i = 0; i < 8; i++) send_word(16'hFFFF, 4'h1);
    tick();
    check_eq("t3_writes", 140'(writes - w0), 140'(1));
    check_eq("t3_word", last_word, make_frame(4'h1));

    // Channel mismatch after 4 words restarts the frame.
    w0 = writes; e0 = err_cnt;
    for (int i = 0; i < 4; i++) send_word(16'h2000 + 16'(i), 4'h2);
    check_eq("t4_no_err", 140'(err_chan), 140'(0));
    for (int i = 0; i < 8; i++) fw[i] = 16'h5000 + 16'(i * 3);
    send_word(fw[0], 4'h5);
    check_eq("t4_err_pulse", 140'(err_chan), 140'(1));
    for (int i = 1; i < 8; i++) send_word(fw[i], 4'h5);
    tick();
    check_eq("t4_err_cnt", 140'(err_cnt - e0), 140'(1));
    check_eq("t4_writes", 140'(writes - w0), 140'(1));
    check_eq("t4_word", last_word, make_frame(4'h5));

    // Two frames back-to-back with in_valid held high.
    w0 = writes; n = 0; rdy_cnt = 0; rdy9 = 1'b1; rdy18 = 1'b1;
    in_valid = 1'b1; in_chan = 4'h9;
    for (int k = 1; k <= 18; k++) begin
      in_data = 16'h0100 + 16'(n);
      #1;
      rdy = in_ready;
      if (rdy) rdy_cnt++;
      if (k == 9) rdy9 = rdy;
      if (k == 18) rdy18 = rdy;
      @(posedge clk_in);
      if (rdy) n++;
      #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) fw[i] = 16'h0108 + 16'(i);
    check_eq("t5_writes", 140'(writes - w0), 140'(2));
    check_eq("t5_ready_c9", 140'(rdy9), 140'(0));
    check_eq("t5_ready_c18", 140'(rdy18), 140'(0));
    check_eq("t5_ready_cnt", 140'(rdy_cnt), 140'(16));
    check_eq("t5_word", last_word, make_frame(4'h9));
    check_eq("t5_cnt", 140'(frame_cnt), 140'(6));

    // Reset while holding a frame.
    w0 = writes;
    fifo_full = 1'b1;
    for (int i = 0; i < 8; i++) send_word(16'hC000 + 16'(i), 4'hC);
    check_eq("t6_w_en_hi", 140'(fifo_w_enable), 140'(1));
    @(negedge clk_in); rst_n = 1'b0;
    #1;
    check_eq("t6_w_en", 140'(fifo_w_enable), 140'(0));
    check_eq("t6_data", data_to_fifo, 140'h0);
    check_eq("t6_cnt", 140'(frame_cnt), 140'(0));
    check_eq("t6_err", 140'(err_chan), 140'(0));
    check_eq("t6_ready", 140'(in_ready), 140'(1));
    tick(); tick();
    @(negedge clk_in); rst_n = 1'b1; fifo_full = 1'b0;
    tick(); tick();
    check_eq("t6_writes", 140'(writes - w0), 140'(0));
    check_eq("t6_w_en_after", 140'(fifo_w_enable), 140'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
